// File: rtl/uart_rx_hex_monitor.sv
// ---------------------------------------------------------------------------
// uart_rx_hex_monitor
//
// Fabric-side UART receiver that listens on the SoC transmit line. Each good
// byte is delivered with a one-cycle strobe. The last four bytes are kept in
// a history register and shown on eight active-low 7-segment displays:
// the newest byte is on hex1:hex0 and the oldest on hex7:hex6.
//
// Frame format: 8N1 by default. If UART_RX_PARITY_EN is defined, the frame
// is 8E1 and parity_err becomes active.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   rxd            serial input (idle high, asynchronous to clk)
//   rx_data[7:0]   last good byte
//   rx_valid       one-cycle strobe when rx_data updates
//   frame_err      one-cycle strobe on a bad (low) stop bit
//   parity_err     one-cycle strobe on parity mismatch (0 in 8N1 builds)
//   hex0..hex7     active-low segments, bit0=a ... bit6=g
// ---------------------------------------------------------------------------
module uart_rx_hex_monitor #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int DIV    = (CLK_HZ + BAUD * 8) / (BAUD * 16)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3,
  output logic [6:0] hex4,
  output logic [6:0] hex5,
  output logic [6:0] hex6,
  output logic [6:0] hex7
);

  localparam int TW = $clog2(DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  // Active-low segment code for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchroniser. It resets to the idle level, so leaving reset never
  // looks like a start edge.
  // ---------------------------------------------------------------------------
  logic sync_q, rs_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours (the synchroniser depends on it).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 1'b1;
      rs_q   <= 1'b1;
    end else begin
      sync_q <= rxd;
      rs_q   <= sync_q;
    end
  end

  // ---------------------------------------------------------------------------
  // 1/16-bit tick generator. It is held at 0 in IDLE, so the tick phase lines
  // up with the detected start edge.
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic            tick;

  assign tick = (state_q != S_IDLE) && (tick_cnt_q == TICK_MAX);

  always_comb begin
    if (state_q == S_IDLE || tick_cnt_q == TICK_MAX) tick_cnt_d = '0;
    else                                             tick_cnt_d = tick_cnt_q + TW'(1);
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  logic [3:0]  samp_cnt_q, samp_cnt_d;   // ticks into the current bit
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic [7:0]  shift_q,    shift_d;
  logic [7:0]  rx_data_q,  rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;
  logic [31:0] hist_q,     hist_d;       // byte 0 (bits 7:0) is the newest
`ifdef UART_RX_PARITY_EN
  logic        par_bad_q,  par_bad_d;
  logic        parity_err_q, parity_err_d;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    samp_cnt_d  = samp_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    hist_d      = hist_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    // The 4-bit sample counter wraps 15 -> 0, which starts the next bit.
    if (tick) samp_cnt_d = samp_cnt_q + 4'd1;

    case (state_q)
      S_IDLE: begin
        samp_cnt_d = '0;
        bit_idx_d  = '0;
        if (!rs_q) state_d = S_START;
      end

      S_START: begin
        // Mid start bit. A line that is high again here was a glitch.
        if (tick && samp_cnt_q == 4'd7) begin
          samp_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = rs_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (tick && samp_cnt_q == 4'd15) begin
          shift_d   = {rs_q, shift_q[7:1]};  // LSB arrives first
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick && samp_cnt_q == 4'd15) begin
          // Even parity: data plus parity bit must hold an even number of ones.
          par_bad_d = rs_q ^ (^shift_q);
          state_d   = S_STOP;
        end
      end
`endif

      S_STOP: begin
        if (tick && samp_cnt_q == 4'd15) begin
          if (rs_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            hist_d     = {hist_q[23:0], shift_q};
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
            // Returning to IDLE now lets a start edge right after the stop
            // mid-sample be accepted.
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // Wait for the line to go high so that a held-low line cannot re-trigger.
        if (rs_q) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the four-byte history is plain registers with a reset value, not a
  // RAM, because the displays must read "0" right after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      samp_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      hist_q      <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      hist_q      <= hist_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Registered display drive. It lags the history by one cycle.
  // ---------------------------------------------------------------------------
  logic [7:0][6:0] hex_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_q <= {8{7'h40}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        hex_q[2*i]   <= seg7(hist_q[8*i +: 4]);
        hex_q[2*i+1] <= seg7(hist_q[8*i+4 +: 4]);
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign hex0 = hex_q[0];
  assign hex1 = hex_q[1];
  assign hex2 = hex_q[2];
  assign hex3 = hex_q[3];
  assign hex4 = hex_q[4];
  assign hex5 = hex_q[5];
  assign hex6 = hex_q[6];
  assign hex7 = hex_q[7];

endmodule

// File: tb/tb_uart_rx_hex_monitor.sv
// ---------------------------------------------------------------------------
// Testbench for uart_rx_hex_monitor at DIV=4 (7.3728 MHz, 115200 baud).
// Expected bytes are pushed to a scoreboard when a frame is driven. A monitor
// pops an entry on each rx_valid and checks the data, the parity flag and the
// latency. Each scenario task makes its own additional checks.
// ---------------------------------------------------------------------------
module tb_uart_rx_hex_monitor;

  localparam int CLK_HZ = 7372800;
  localparam int BAUD   = 115200;
  localparam int DIV    = 4;
  localparam int BIT    = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS  = 10;
`else
  localparam int NBITS  = 9;
`endif
  // Cycles from the falling edge of the start bit to rx_valid.
  localparam int LAT    = 2 + (8 + 16 * NBITS) * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err;
  logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [55:0] hex_all;

  assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

  uart_rx_hex_monitor #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .parity_err(parity_err),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
    .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    int         start_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [7:0] hist_m [4] = '{8'h00, 8'h00, 8'h00, 8'h00};

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0, fe_cnt = 0, pe_cnt = 0;
  bit prev_valid = 1'b0, prev_fe = 1'b0;
  int lat;

  function automatic logic [55:0] exp_hex();
    logic [55:0] h;
    for (int i = 0; i < 4; i++) begin
      h[14*i +: 7]     = seg_tab[hist_m[i][3:0]];
      h[14*i + 7 +: 7] = seg_tab[hist_m[i][7:4]];
    end
    return h;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_valid: got rx_valid with rx_data=%h, expected no strobe", rx_data);
      end else begin
        mon_e = sb.pop_front();
        if (rx_data !== mon_e.data) begin
          n_errors++;
          $display("FAIL rx_data: got %h, expected %h", rx_data, mon_e.data);
        end
        n_checks++;
        if (parity_err !== mon_e.perr) begin
          n_errors++;
          $display("FAIL parity_flag: got %b, expected %b (byte %h)", parity_err, mon_e.perr, mon_e.data);
        end
        n_checks++;
        lat = cyc - mon_e.start_cyc;
        if (lat < LAT - DIV || lat > LAT + DIV) begin
          n_errors++;
          $display("FAIL latency: got %0d cycles, expected %0d +/- %0d", lat, LAT, DIV);
        end
        hist_m[3] = hist_m[2];
        hist_m[2] = hist_m[1];
        hist_m[1] = hist_m[0];
        hist_m[0] = mon_e.data;
      end
    end
    if (rx_valid && prev_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL valid_width: rx_valid high for 2 cycles, expected 1");
    end
    if (frame_err) begin
      fe_cnt++;
      if (prev_fe) begin
        n_checks++;
        n_errors++;
        $display("FAIL frame_err_width: high for 2 cycles, expected 1");
      end
    end
    if (parity_err) begin
      pe_cnt++;
      if (!rx_valid) begin
        n_checks++;
        n_errors++;
        $display("FAIL parity_alone: parity_err=1 with rx_valid=0, expected together");
      end
    end
    prev_valid = rx_valid;
    prev_fe    = frame_err;
  end

  // ---------------- stimulus helpers ----------------
  // All drive helpers start and end 1 time unit after a rising edge.
  task automatic hold(input logic v, input int n);
    rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int stop_len, input bit push, input bit perr);
    exp_t e;
    if (push) begin
      e.data = d;
      e.perr = perr;
      e.start_cyc = cyc;
      sb.push_back(e);
    end
    hold(1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(d[i], BIT);
`ifdef UART_RX_PARITY_EN
    hold(par, BIT);
`else
    if (par === 1'bx) hold(1'b1, 1);
`endif
    hold(stop, stop_len);
  endtask

  task automatic send_byte(input logic [7:0] d, input int stop_len);
    send_frame(d, ^d, 1'b1, stop_len, 1'b1, 1'b0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 * BIT && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expected bytes never delivered, expected 0 pending", sb.size());
      sb.delete();
    end
    hold(1'b1, 4);   // let the registered displays catch up
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got data=%h v=%b fe=%b pe=%b, expected 00 0 0 0",
               rx_data, rx_valid, frame_err, parity_err);
    end
    n_checks++;
    if (hex_all !== {8{7'h40}}) begin
      n_errors++;
      $display("FAIL reset_hex: got %h, expected all 40", hex_all);
    end
  endtask

  task automatic test_basic();
    int v0 = valid_cnt;
    send_byte(8'h55, BIT);
    send_byte(8'hA3, BIT);
    wait_drain();
    n_checks++;
    if (valid_cnt - v0 != 2) begin
      n_errors++;
      $display("FAIL basic_count: got %0d strobes, expected 2", valid_cnt - v0);
    end
    n_checks++;
    if ({hex3, hex2, hex1, hex0} !== {7'h12, 7'h12, 7'h08, 7'h30}) begin
      n_errors++;
      $display("FAIL basic_hex: got %h %h %h %h, expected 12 12 08 30", hex3, hex2, hex1, hex0);
    end
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt;
    int f0 = fe_cnt;
    hold(1'b0, 3 * DIV);
    hold(1'b1, 2 * BIT);
    n_checks++;
    if (valid_cnt != v0 || fe_cnt != f0) begin
      n_errors++;
      $display("FAIL glitch_strobe: got %0d valid %0d frame_err, expected 0 0", valid_cnt - v0, fe_cnt - f0);
    end
    send_byte(8'h7E, BIT);
    wait_drain();
    n_checks++;
    if (rx_data !== 8'h7E) begin
      n_errors++;
      $display("FAIL glitch_next: got %h, expected 7e", rx_data);
    end
  endtask

  task automatic test_framing();
    int v0 = valid_cnt;
    int f0 = fe_cnt;
    send_frame(8'h31, ^8'h31, 1'b0, BIT + 40 * BIT, 1'b0, 1'b0);
    hold(1'b1, BIT);
    send_byte(8'h32, BIT);
    wait_drain();
    n_checks++;
    if (fe_cnt - f0 != 1) begin
      n_errors++;
      $display("FAIL frame_err_count: got %0d, expected 1", fe_cnt - f0);
    end
    n_checks++;
    if (valid_cnt - v0 != 1) begin
      n_errors++;
      $display("FAIL frame_valid_count: got %0d, expected 1", valid_cnt - v0);
    end
    n_checks++;
    if ({hex1, hex0} !== {7'h30, 7'h24}) begin
      n_errors++;
      $display("FAIL frame_hex: got %h %h, expected 30 24", hex1, hex0);
    end
  endtask

  task automatic test_history();
    for (int b = 1; b <= 5; b++) send_byte(8'(b), BIT);
    wait_drain();
    n_checks++;
    if (hex_all !== {7'h40, 7'h24, 7'h40, 7'h30, 7'h40, 7'h19, 7'h40, 7'h12}) begin
      n_errors++;
      $display("FAIL history_hex: got %h, expected 40 24 40 30 40 19 40 12", hex_all);
    end
  endtask

  task automatic test_parity();
    int p0 = pe_cnt;
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1, BIT, 1'b1, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1, BIT, 1'b1, 1'b0);
    wait_drain();
    n_checks++;
    if (pe_cnt - p0 != 1) begin
      n_errors++;
      $display("FAIL parity_count: got %0d, expected 1", pe_cnt - p0);
    end
`else
    send_byte(8'h07, BIT);
    wait_drain();
    n_checks++;
    if (pe_cnt != 0 || pe_cnt != p0) begin
      n_errors++;
      $display("FAIL parity_tied: got %0d parity_err pulses, expected 0", pe_cnt);
    end
`endif
    n_checks++;
    if (rx_data !== 8'h07) begin
      n_errors++;
      $display("FAIL parity_data: got %h, expected 07", rx_data);
    end
  endtask

  task automatic test_back_to_back();
    int v0 = valid_cnt;
    logic [7:0] bytes [4] = '{8'hC3, 8'h5A, 8'hFF, 8'h00};
    // Stop bit cut just past its mid-sample, so each next start edge is early.
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 8 * DIV + 4);
    hold(1'b1, BIT);
    wait_drain();
    n_checks++;
    if (valid_cnt - v0 != 4) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d, expected 4", valid_cnt - v0);
    end
    n_checks++;
    if (hex_all !== exp_hex()) begin
      n_errors++;
      $display("FAIL b2b_hex: got %h, expected %h", hex_all, exp_hex());
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    hold(1'b0, BIT);
    hold(1'b1, BIT);
    hold(1'b0, BIT / 2);
    reset = 1'b1;
    rxd   = 1'b1;
    #1;
    n_checks++;
    if (rx_data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || parity_err !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_outputs: got data=%h v=%b fe=%b pe=%b, expected 00 0 0 0",
               rx_data, rx_valid, frame_err, parity_err);
    end
    n_checks++;
    if (hex_all !== {8{7'h40}}) begin
      n_errors++;
      $display("FAIL midreset_hex: got %h, expected all 40", hex_all);
    end
    for (int i = 0; i < 4; i++) hist_m[i] = 8'h00;
    hold(1'b1, 5);
    reset = 1'b0;
    v0 = valid_cnt;
    f0 = fe_cnt;
    hold(1'b1, 2 * 12 * BIT);
    n_checks++;
    if (valid_cnt != v0 || fe_cnt != f0) begin
      n_errors++;
      $display("FAIL midreset_strobe: got %0d valid %0d frame_err, expected 0 0", valid_cnt - v0, fe_cnt - f0);
    end
    send_byte(8'h3C, BIT);
    wait_drain();
    n_checks++;
    if (hex_all !== exp_hex() || rx_data !== 8'h3C) begin
      n_errors++;
      $display("FAIL midreset_next: got data=%h hex=%h, expected 3c hex=%h", rx_data, hex_all, exp_hex());
    end
  endtask

  initial begin
    reset = 1'b1;
    rxd   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    hold(1'b1, 20);
    test_basic();
    test_glitch();
    test_framing();
    test_history();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
